// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter for the register file write port.
// Tracks pending destination registers for hazard detection.
module regfile_wb_scheduler #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wb0_valid,
   input  logic [4:0]   wb0_rd,
   input  logic [N-1:0] wb0_data,
   output logic         wb0_ready,
   input  logic         wb1_valid,
   input  logic [4:0]   wb1_rd,
   input  logic [N-1:0] wb1_data,
   output logic         wb1_ready,
   output logic         rf_write,
   output logic [4:0]   rf_write_reg,
   output logic [N-1:0] rf_write_data,
   input  logic         iss_valid,
   input  logic [4:0]   iss_rd,
   input  logic [4:0]   rs1,
   input  logic [4:0]   rs2,
   output logic         hazard,
   input  logic         flush,
   output logic [31:0]  busy_vec
);

   // 1 means wb1 was granted most recently
   logic         last_q;
   logic         gnt0;
   logic         gnt1;
   logic         hs;
   logic [4:0]   hs_rd;
   logic [N-1:0] hs_data;
   logic         rf_write_q;
   logic [4:0]   rf_reg_q;
   logic [N-1:0] rf_data_q;
   logic [31:0]  busy_q;
   logic [31:0]  busy_d;

   always_comb begin
      gnt0 = wb0_valid & (~wb1_valid | last_q);
      gnt1 = wb1_valid & ~gnt0;
   end

   assign hs      = gnt0 | gnt1;
   assign hs_rd   = gnt0 ? wb0_rd : wb1_rd;
   assign hs_data = gnt0 ? wb0_data : wb1_data;

   // Clear, then set, then flush: later wins
   always_comb begin
      busy_d = busy_q;
      if (hs) begin
         busy_d[hs_rd] = 1'b0;
      end
      if (iss_valid) begin
         busy_d[iss_rd] = 1'b1;
      end
      if (flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q     <= 1'b1;
         rf_write_q <= 1'b0;
         rf_reg_q   <= '0;
         rf_data_q  <= '0;
         busy_q     <= '0;
      end else begin
         if (hs) begin
            last_q <= gnt1;
         end
         rf_write_q <= hs & (hs_rd != 5'd0);
         if (hs && (hs_rd != 5'd0)) begin
            rf_reg_q  <= hs_rd;
            rf_data_q <= hs_data;
         end
         busy_q <= busy_d;
      end
   end

   assign wb0_ready     = gnt0;
   assign wb1_ready     = gnt1;
   assign rf_write      = rf_write_q;
   assign rf_write_reg  = rf_reg_q;
   assign rf_write_data = rf_data_q;
   assign busy_vec      = busy_q;
   assign hazard        = busy_q[rs1] | busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized scoreboard bench for regfile_wb_scheduler.
// Reference model applies arbitration/reservation rules directly.
module tb_regfile_wb_scheduler;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         wb0_valid = 1'b0;
   logic [4:0]   wb0_rd = '0;
   logic [N-1:0] wb0_data = '0;
   logic         wb0_ready;
   logic         wb1_valid = 1'b0;
   logic [4:0]   wb1_rd = '0;
   logic [N-1:0] wb1_data = '0;
   logic         wb1_ready;
   logic         rf_write;
   logic [4:0]   rf_write_reg;
   logic [N-1:0] rf_write_data;
   logic         iss_valid = 1'b0;
   logic [4:0]   iss_rd = '0;
   logic [4:0]   rs1 = '0;
   logic [4:0]   rs2 = '0;
   logic         hazard;
   logic         flush = 1'b0;
   logic [31:0]  busy_vec;

   regfile_wb_scheduler #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .wb0_valid(wb0_valid), .wb0_rd(wb0_rd),
      .wb0_data(wb0_data), .wb0_ready(wb0_ready),
      .wb1_valid(wb1_valid), .wb1_rd(wb1_rd),
      .wb1_data(wb1_data), .wb1_ready(wb1_ready),
      .rf_write(rf_write), .rf_write_reg(rf_write_reg),
      .rf_write_data(rf_write_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .rs1(rs1), .rs2(rs2), .hazard(hazard),
      .flush(flush), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tgt;
      logic [4:0]  rd;
      logic [31:0] d;
   } wr_t;

   wr_t         q[$];
   int          checks = 0;
   int          errors = 0;
   int          ecount = 0;
   int          m_last = 1;
   logic [31:0] m_busy = '0;
   logic [4:0]  m_reg = '0;
   logic [31:0] m_data = '0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_last = 1;
      m_busy = '0;
      m_reg  = '0;
      m_data = '0;
   endtask

   task automatic drive(
      input logic v0, input logic [4:0] r0, input logic [31:0] d0,
      input logic v1, input logic [4:0] r1, input logic [31:0] d1,
      input logic iv, input logic [4:0] ir,
      input logic [4:0] s1, input logic [4:0] s2, input logic fl);
      int g;
      logic [4:0]  grd;
      logic [31:0] gd;
      logic [31:0] nb;
      @(negedge clk);
      wb0_valid = v0; wb0_rd = r0; wb0_data = d0;
      wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
      iss_valid = iv; iss_rd = ir;
      rs1 = s1; rs2 = s2; flush = fl;
      #4;
      if (v0 && v1) g = (m_last == 1) ? 0 : 1;
      else if (v0) g = 0;
      else if (v1) g = 1;
      else g = -1;
      chk("wb0_ready", 64'(wb0_ready), 64'(g == 0));
      chk("wb1_ready", 64'(wb1_ready), 64'(g == 1));
      chk("hazard", 64'(hazard), 64'(m_busy[s1] | m_busy[s2]));
      if (rst) begin
         nb = m_busy;
         if (g >= 0) begin
            grd = (g == 0) ? r0 : r1;
            gd  = (g == 0) ? d0 : d1;
            m_last = g;
            if (grd != 0) q.push_back('{ecount + 1, grd, gd});
            nb[grd] = 1'b0;
         end
         if (iv) nb[ir] = 1'b1;
         if (fl) nb = '0;
         nb[0] = 1'b0;
         m_busy = nb;
      end
      @(posedge clk);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(posedge clk) begin
      wr_t e;
      #1;
      ecount++;
      if (rst) begin
         chk("busy_vec", 64'(busy_vec), 64'(m_busy));
         if (q.size() > 0 && q[0].tgt == ecount) begin
            e = q.pop_front();
            m_reg  = e.rd;
            m_data = e.d;
            chk("rf_write", 64'(rf_write), 64'd1);
         end else begin
            chk("rf_write", 64'(rf_write), 64'd0);
         end
         chk("rf_write_reg", 64'(rf_write_reg), 64'(m_reg));
         chk("rf_write_data", 64'(rf_write_data), 64'(m_data));
      end
   end

   initial begin
      #1;
      chk("rst rf_write", 64'(rf_write), 64'd0);
      chk("rst rf_write_reg", 64'(rf_write_reg), 64'd0);
      chk("rst rf_write_data", 64'(rf_write_data), 64'd0);
      chk("rst busy_vec", 64'(busy_vec), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      repeat (3) drive(1, 5, 32'hAAAA0000, 1, 6, 32'h1234, 0, 0, 0, 0, 0);
      idle();
      drive(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
      idle();

      drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
      drive(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);

      drive(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0);
      drive(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 9, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0);

      drive(0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 3, 8, 11, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 9, 0);

      drive(1, 4, 32'h4444, 0, 0, 0, 1, 12, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst rf_write", 64'(rf_write), 64'd0);
      chk("arst rf_write_reg", 64'(rf_write_reg), 64'd0);
      chk("arst rf_write_data", 64'(rf_write_data), 64'd0);
      chk("arst busy_vec", 64'(busy_vec), 64'd0);
      model_reset();
      drive(1, 4, 32'h4444, 1, 13, 32'h13, 1, 14, 14, 12, 0);
      @(negedge clk);
      rst = 1'b1;
      wb0_valid = 0; wb1_valid = 0;
      iss_valid = 0; flush = 0;
      repeat (2) idle();

      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 1) == 1,
               5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 1) == 1,
               5'($urandom_range(0, 31)), $urandom,
               $urandom_range(0, 2) != 0,
               5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)),
               $urandom_range(0, 15) == 0);
      end
      repeat (2) idle();
      chk("queue drained", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
